// File: rtl/lsc_i2cs_ext.sv
// lsc_i2cs_ext: oversampled I2C slave front end for register-file access.
//   Filters SCL/SDA with a hysteresis filter, detects START/STOP, matches a
//   masked 7-bit device address, then loads a 1- or 2-byte register address
//   and streams write/read bytes with address auto-increment.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   i_dev_addr/i_dev_mask device address and don't-care mask
//   o_dev_addr            last matched device address
//   o_reg_addr            current register address
//   i_rdata/o_rd          register read data / one-cycle read request
//   o_wdata/o_wr          register write data / one-cycle write strobe
//   o_start/o_stop/o_busy bus status
//   i_scl/i_sda           pad inputs
//   o_sda_oe/o_scl_oe     open-drain pull-low enables
// Optional macro LSC_I2CS_CLK_STRETCH_EN: adds input i_rdy and stretches SCL
//   on reads until the register file signals ready.
module lsc_i2cs_ext #(
  parameter int unsigned FILT_LEN   = 5,
  parameter int unsigned ADDR_BYTES = 1,
  parameter int unsigned RA_W       = 8 * ADDR_BYTES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      i_dev_addr,
  input  logic [6:0]      i_dev_mask,
  output logic [6:0]      o_dev_addr,
  output logic [RA_W-1:0] o_reg_addr,
  input  logic [7:0]      i_rdata,
`ifdef LSC_I2CS_CLK_STRETCH_EN
  input  logic            i_rdy,
`endif
  output logic [7:0]      o_wdata,
  output logic            o_wr,
  output logic            o_rd,
  output logic            o_start,
  output logic            o_stop,
  output logic            o_busy,
  input  logic            i_scl,
  input  logic            i_sda,
  output logic            o_sda_oe,
  output logic            o_scl_oe
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, RADDR, RADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

`ifdef LSC_I2CS_CLK_STRETCH_EN
  localparam logic [1:0] RD_WAIT = 2'd1;
`else
  localparam logic [1:0] RD_WAIT = 2'd2;
`endif
  localparam logic LAST_ABYTE = 1'(ADDR_BYTES - 1);

  // Input filter and edge-detect registers
  logic [FILT_LEN-1:0] scl_sh_q, scl_sh_d, sda_sh_q, sda_sh_d;
  logic                scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic                scl_p_q, scl_p_d, sda_p_q, sda_p_d;

  // Protocol state
  state_t              state_q, state_d;
  logic [2:0]          bcnt_q, bcnt_d;
  logic                abyte_q, abyte_d;
  logic                ph_q, ph_d;
  logic                rw_q, rw_d;
  logic [6:0]          rx_q, rx_d;
  logic [6:0]          tx_q, tx_d;
  logic [1:0]          rdly_q, rdly_d;

  // Registered outputs
  logic                sda_oe_q, sda_oe_d;
  logic                wr_q, wr_d, rd_q, rd_d;
  logic                start_q, start_d, stop_q, stop_d;
  logic                busy_q, busy_d;
  logic [6:0]          dev_addr_q, dev_addr_d;
  logic [RA_W-1:0]     reg_addr_q, reg_addr_d;
  logic [7:0]          wdata_q, wdata_d;
`ifdef LSC_I2CS_CLK_STRETCH_EN
  logic                scl_oe_q, scl_oe_d;
`endif

  logic                scl_rise_c, scl_fall_c, start_c, stop_c;
  logic [7:0]          rx_byte_c;
  logic                match_c;
  logic                launch_c;

  // Hysteresis filter: switch only when every sample agrees
  always_comb begin
    scl_sh_d = {scl_sh_q[FILT_LEN-2:0], i_scl};
    sda_sh_d = {sda_sh_q[FILT_LEN-2:0], i_sda};
    scl_f_d  = scl_f_q;
    sda_f_d  = sda_f_q;
    if (&scl_sh_q)       scl_f_d = 1'b1;
    else if (~|scl_sh_q) scl_f_d = 1'b0;
    if (&sda_sh_q)       sda_f_d = 1'b1;
    else if (~|sda_sh_q) sda_f_d = 1'b0;
    scl_p_d  = scl_f_q;
    sda_p_d  = sda_f_q;
  end

  // Bus events; START/STOP require SCL high on both samples
  assign scl_rise_c = scl_f_q & ~scl_p_q;
  assign scl_fall_c = ~scl_f_q & scl_p_q;
  assign start_c    = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop_c     = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;
  assign rx_byte_c  = {rx_q, sda_f_q};
  assign match_c    = ((rx_byte_c[7:1] ^ i_dev_addr) & ~i_dev_mask) == 7'd0;

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    abyte_d    = abyte_q;
    ph_d       = ph_q;
    rw_d       = rw_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    rdly_d     = rdly_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    dev_addr_d = dev_addr_q;
    reg_addr_d = reg_addr_q;
    wdata_d    = wdata_q;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    launch_c   = 1'b0;
`ifdef LSC_I2CS_CLK_STRETCH_EN
    scl_oe_d   = scl_oe_q;
`endif

    // Address advances the clk after the write strobe
    if (wr_q) reg_addr_d = reg_addr_q + RA_W'(1);

    // Read data capture into the TX shifter; bit 7 goes straight to the pad
`ifdef LSC_I2CS_CLK_STRETCH_EN
    if ((rdly_q != 2'd0) && i_rdy) begin
      tx_d     = i_rdata[6:0];
      sda_oe_d = ~i_rdata[7];
      rdly_d   = 2'd0;
      scl_oe_d = 1'b0;
    end
`else
    if (rdly_q != 2'd0) begin
      rdly_d = rdly_q - 2'd1;
      if (rdly_q == 2'd1) begin
        tx_d     = i_rdata[6:0];
        sda_oe_d = ~i_rdata[7];
      end
    end
`endif

    if (stop_c) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      stop_d   = 1'b1;
      busy_d   = 1'b0;
      rdly_d   = 2'd0;
      ph_d     = 1'b0;
`ifdef LSC_I2CS_CLK_STRETCH_EN
      scl_oe_d = 1'b0;
`endif
    end else if (start_c) begin
      state_d  = DEV;
      bcnt_d   = 3'd0;
      sda_oe_d = 1'b0;
      start_d  = 1'b1;
      rdly_d   = 2'd0;
      ph_d     = 1'b0;
`ifdef LSC_I2CS_CLK_STRETCH_EN
      scl_oe_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: ;
        DEV: begin
          if (scl_rise_c) begin
            rx_d   = rx_byte_c[6:0];
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
              if (match_c) begin
                dev_addr_d = rx_byte_c[7:1];
                rw_d       = rx_byte_c[0];
                busy_d     = 1'b1;
                ph_d       = 1'b0;
                state_d    = DEV_ACK;
              end else begin
                busy_d  = 1'b0;
                state_d = IDLE;
              end
            end
          end
        end
        RADDR, WDATA: begin
          if (scl_rise_c) begin
            rx_d   = rx_byte_c[6:0];
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
              ph_d = 1'b0;
              if (state_q == RADDR) begin
                // Shift-load: the final ADDR_BYTES bytes form the address, MSB first
                reg_addr_d = RA_W'({reg_addr_q, rx_byte_c});
                state_d    = RADDR_ACK;
              end else begin
                wdata_d = rx_byte_c;
                wr_d    = 1'b1;
                state_d = WDATA_ACK;
              end
            end
          end
        end
        DEV_ACK, RADDR_ACK, WDATA_ACK: begin
          // ph 0: first fall starts the ACK; ph 1: next fall ends the slot
          if (scl_fall_c) begin
            if (!ph_q) begin
              sda_oe_d = 1'b1;
              ph_d     = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              ph_d     = 1'b0;
              bcnt_d   = 3'd0;
              if (state_q == DEV_ACK) begin
                if (rw_q) begin
                  state_d  = RDATA;
                  launch_c = 1'b1;
                end else begin
                  abyte_d = 1'b0;
                  state_d = RADDR;
                end
              end else if (state_q == RADDR_ACK) begin
                if (abyte_q == LAST_ABYTE) begin
                  state_d = WDATA;
                end else begin
                  abyte_d = abyte_q + 1'b1;
                  state_d = RADDR;
                end
              end else begin
                state_d = WDATA;
              end
            end
          end
        end
        RDATA: begin
          // ph 1 here means a read launch is pending for the next fall
          if (scl_rise_c) begin
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
              ph_d    = 1'b0;
              state_d = RDATA_ACK;
            end
          end else if (scl_fall_c) begin
            if (ph_q) begin
              ph_d     = 1'b0;
              launch_c = 1'b1;
            end else begin
              sda_oe_d = ~tx_q[6];
              tx_d     = {tx_q[5:0], 1'b0};
            end
          end
        end
        RDATA_ACK: begin
          if (scl_fall_c && !ph_q) begin
            sda_oe_d = 1'b0;
            ph_d     = 1'b1;
          end else if (scl_rise_c && ph_q) begin
            // Address moves past every byte sent, ACKed or not
            reg_addr_d = reg_addr_q + RA_W'(1);
            bcnt_d     = 3'd0;
            if (!sda_f_q) begin
              ph_d    = 1'b1;
              state_d = RDATA;
            end else begin
              ph_d    = 1'b0;
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Read launch: request the byte and release SDA until it is captured
    if (launch_c) begin
      rd_d     = 1'b1;
      sda_oe_d = 1'b0;
      rdly_d   = RD_WAIT;
`ifdef LSC_I2CS_CLK_STRETCH_EN
      scl_oe_d = 1'b1;
`endif
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sh_q   <= '1;
      sda_sh_q   <= '1;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
      state_q    <= IDLE;
      bcnt_q     <= 3'd0;
      abyte_q    <= 1'b0;
      ph_q       <= 1'b0;
      rw_q       <= 1'b0;
      rx_q       <= 7'd0;
      tx_q       <= 7'd0;
      rdly_q     <= 2'd0;
      sda_oe_q   <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
      dev_addr_q <= 7'd0;
      reg_addr_q <= '0;
      wdata_q    <= 8'd0;
`ifdef LSC_I2CS_CLK_STRETCH_EN
      scl_oe_q   <= 1'b0;
`endif
    end else begin
      scl_sh_q   <= scl_sh_d;
      sda_sh_q   <= sda_sh_d;
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_p_q    <= scl_p_d;
      sda_p_q    <= sda_p_d;
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      abyte_q    <= abyte_d;
      ph_q       <= ph_d;
      rw_q       <= rw_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      rdly_q     <= rdly_d;
      sda_oe_q   <= sda_oe_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      busy_q     <= busy_d;
      dev_addr_q <= dev_addr_d;
      reg_addr_q <= reg_addr_d;
      wdata_q    <= wdata_d;
`ifdef LSC_I2CS_CLK_STRETCH_EN
      scl_oe_q   <= scl_oe_d;
`endif
    end
  end

  assign o_dev_addr = dev_addr_q;
  assign o_reg_addr = reg_addr_q;
  assign o_wdata    = wdata_q;
  assign o_wr       = wr_q;
  assign o_rd       = rd_q;
  assign o_start    = start_q;
  assign o_stop     = stop_q;
  assign o_busy     = busy_q;
  assign o_sda_oe   = sda_oe_q;
`ifdef LSC_I2CS_CLK_STRETCH_EN
  assign o_scl_oe   = scl_oe_q;
`else
  assign o_scl_oe   = 1'b0;
`endif

endmodule
